// File: rtl/obi_mem_arbiter.sv
// rtl/obi_mem_arbiter.sv - two-port OBI request merger with round-robin arbitration and in-order response routing
`timescale 1ns/1ps

module obi_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // instruction-cache refill port
  input  logic        instr_req,
  output logic        instr_gnt,
  input  logic [31:0] instr_addr,
  input  logic        instr_we,
  input  logic [3:0]  instr_be,
  input  logic [31:0] instr_wdata,
  output logic        instr_rvalid,
  output logic [31:0] instr_rdata,
  // data-cache refill/writeback port
  input  logic        data_req,
  output logic        data_gnt,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_wdata,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  // merged host bus port
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy_o,
  output logic        err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic                       rr_q;
  logic                       lock_q;
  logic                       lock_src_q;
  logic [MAX_OUTSTANDING-1:0] route_q;
  logic [PW-1:0]              wptr_q;
  logic [PW-1:0]              rptr_q;
  logic [CW-1:0]              count_q;
  logic                       err_q;

  logic sel;
  logic sel_req;
  logic full;
  logic empty;
  logic handshake;
  logic pop;
  logic head;

  // A stalled request stays locked to its port so OBI address/data remain stable.
  always_comb begin
    sel = rr_q;
    if (lock_q) begin
      sel = lock_src_q;
    end else if (instr_req && !data_req) begin
      sel = 1'b0;
    end else if (data_req && !instr_req) begin
      sel = 1'b1;
    end
  end

  assign full      = (count_q == CW'(MAX_OUTSTANDING));
  assign empty     = (count_q == '0);
  assign sel_req   = sel ? data_req : instr_req;
  assign mem_req   = sel_req && !full;
  assign handshake = mem_req && mem_gnt;

  assign mem_addr  = sel ? data_addr  : instr_addr;
  assign mem_we    = sel ? data_we    : instr_we;
  assign mem_be    = sel ? data_be    : instr_be;
  assign mem_wdata = sel ? data_wdata : instr_wdata;

  assign instr_gnt = !sel && mem_req && mem_gnt;
  assign data_gnt  =  sel && mem_req && mem_gnt;

  assign head         = route_q[rptr_q];
  assign pop          = mem_rvalid && !empty;
  assign instr_rvalid = pop && !head;
  assign data_rvalid  = pop &&  head;
  assign instr_rdata  = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign busy_o = (count_q != '0);
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= 1'b0;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
      route_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (handshake) begin
        route_q[wptr_q] <= sel;
        wptr_q          <= wptr_q + PW'(1);
        rr_q            <= ~sel;
        lock_q          <= 1'b0;
      end else if (mem_req) begin
        lock_q     <= 1'b1;
        lock_src_q <= sel;
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      case ({handshake, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A response with nothing outstanding is dropped and flagged until reset.
      if (mem_rvalid && empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb/tb_obi_mem_arbiter.sv - directed self-checking bench for obi_mem_arbiter
`timescale 1ns/1ps

module tb_obi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req, instr_gnt, instr_we, instr_rvalid;
  logic [31:0] instr_addr, instr_wdata, instr_rdata;
  logic [3:0]  instr_be;
  logic        data_req, data_gnt, data_we, data_rvalid;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy_o, err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_addr(instr_addr), .instr_we(instr_we),
    .instr_be(instr_be), .instr_wdata(instr_wdata), .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_gnt(data_gnt), .data_addr(data_addr), .data_we(data_we),
    .data_be(data_be), .data_wdata(data_wdata), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    instr_req = 0; instr_addr = 0; instr_we = 0; instr_be = 4'hF; instr_wdata = 0;
    data_req = 0; data_addr = 0; data_we = 0; data_be = 4'hF; data_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst_ni = 0;
    clear_inputs();
    #2;
    rst_ni = 1;
  endtask

  task automatic test_reset;
    rst_ni = 0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({instr_gnt, data_gnt, mem_req, instr_rvalid, data_rvalid, busy_o, err_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000000",
               {instr_gnt, data_gnt, mem_req, instr_rvalid, data_rvalid, busy_o, err_o});
    end
    rst_ni = 1;
  endtask

  task automatic test_single_read;
    do_reset();
    instr_req = 1; instr_addr = 32'h1000; mem_gnt = 1;
    #1;
    checks++;
    if ({mem_req, mem_addr, instr_gnt, data_gnt} !== {1'b1, 32'h1000, 2'b10}) begin
      errors++;
      $display("FAIL single_req got req=%b addr=%h gnt=%b%b exp 1 00001000 10",
               mem_req, mem_addr, instr_gnt, data_gnt);
    end
    tick();
    instr_req = 0; mem_gnt = 0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b exp 1", busy_o); end
    tick();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({busy_o, instr_rvalid, data_rvalid, instr_rdata} !== {3'b110, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_rsp got busy=%b iv=%b dv=%b rdata=%h exp 1 1 0 deadbeef",
               busy_o, instr_rvalid, data_rvalid, instr_rdata);
    end
    tick();
    mem_rvalid = 0;
    #1;
    checks++;
    if ({busy_o, instr_rvalid, err_o} !== 3'b000) begin
      errors++;
      $display("FAIL single_done got busy=%b iv=%b err=%b exp 0 0 0", busy_o, instr_rvalid, err_o);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp;
    do_reset();
    instr_req = 1; data_req = 1; instr_addr = 32'h100; data_addr = 32'h200; mem_gnt = 1;
    for (int i = 0; i < 6; i++) begin
      mem_rvalid = (i > 0);
      mem_rdata = 32'hA000 + i;
      #1;
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({instr_gnt, data_gnt} !== exp) begin
        errors++;
        $display("FAIL rr_gnt[%0d] got %b%b exp %b", i, instr_gnt, data_gnt, exp);
      end
      if (i > 0) begin
        exp = ((i - 1) % 2 == 0) ? 2'b10 : 2'b01;
        checks++;
        if ({instr_rvalid, data_rvalid} !== exp) begin
          errors++;
          $display("FAIL rr_route[%0d] got %b%b exp %b", i, instr_rvalid, data_rvalid, exp);
        end
      end
      tick();
    end
    instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 1;
    #1;
    checks++;
    if ({instr_rvalid, data_rvalid} !== 2'b01) begin
      errors++;
      $display("FAIL rr_last_route got %b%b exp 01", instr_rvalid, data_rvalid);
    end
    tick();
    mem_rvalid = 0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_idle_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_gnt_stall;
    do_reset();
    instr_addr = 32'h1000; instr_wdata = 32'h1111;
    data_addr = 32'h2000; data_wdata = 32'h2222;
    data_req = 1; mem_gnt = 0;
    #1;
    checks++;
    if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h2000, 32'h2222}) begin
      errors++;
      $display("FAIL stall_first got req=%b addr=%h wdata=%h exp 1 00002000 00002222",
               mem_req, mem_addr, mem_wdata);
    end
    tick();
    instr_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({mem_req, mem_addr, mem_wdata, instr_gnt, data_gnt} !== {1'b1, 32'h2000, 32'h2222, 2'b00}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got req=%b addr=%h wdata=%h gnt=%b%b exp 1 00002000 00002222 00",
                 i, mem_req, mem_addr, mem_wdata, instr_gnt, data_gnt);
      end
      tick();
    end
    mem_gnt = 1;
    #1;
    checks++;
    if ({instr_gnt, data_gnt, mem_addr} !== {2'b01, 32'h2000}) begin
      errors++;
      $display("FAIL stall_release got gnt=%b%b addr=%h exp 01 00002000", instr_gnt, data_gnt, mem_addr);
    end
    tick();
    checks++;
    if ({instr_gnt, data_gnt, mem_addr, mem_wdata} !== {2'b10, 32'h1000, 32'h1111}) begin
      errors++;
      $display("FAIL stall_other got gnt=%b%b addr=%h wdata=%h exp 10 00001000 00001111",
               instr_gnt, data_gnt, mem_addr, mem_wdata);
    end
    tick();
    instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 1;
    #1;
    checks++;
    if ({instr_rvalid, data_rvalid} !== 2'b01) begin
      errors++;
      $display("FAIL stall_rsp0 got %b%b exp 01", instr_rvalid, data_rvalid);
    end
    tick();
    checks++;
    if ({instr_rvalid, data_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL stall_rsp1 got %b%b exp 10", instr_rvalid, data_rvalid);
    end
    tick();
    mem_rvalid = 0;
  endtask

  task automatic test_full;
    logic exp;
    do_reset();
    instr_req = 1; instr_addr = 32'h3000; mem_gnt = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = (i < 4);
      checks++;
      if ({mem_req, instr_gnt} !== {exp, exp}) begin
        errors++;
        $display("FAIL full_gnt[%0d] got req=%b gnt=%b exp %b %b", i, mem_req, instr_gnt, exp, exp);
      end
      tick();
    end
    mem_rvalid = 1;
    #1;
    checks++;
    if ({mem_req, instr_gnt, instr_rvalid} !== 3'b001) begin
      errors++;
      $display("FAIL full_pop_blocked got req=%b gnt=%b iv=%b exp 0 0 1", mem_req, instr_gnt, instr_rvalid);
    end
    tick();
    mem_rvalid = 0;
    #1;
    checks++;
    if ({mem_req, instr_gnt} !== 2'b11) begin
      errors++;
      $display("FAIL full_fifth got req=%b gnt=%b exp 1 1", mem_req, instr_gnt);
    end
    tick();
    instr_req = 0; mem_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1;
      #1;
      checks++;
      if (instr_rvalid !== 1'b1) begin errors++; $display("FAIL full_drain[%0d] got %b exp 1", i, instr_rvalid); end
      tick();
    end
    mem_rvalid = 0;
    #1;
    checks++;
    if ({busy_o, err_o} !== 2'b00) begin
      errors++;
      $display("FAIL full_idle got busy=%b err=%b exp 0 0", busy_o, err_o);
    end
  endtask

  task automatic test_interleaved;
    logic [31:0] rd [3];
    logic [1:0]  route [3];
    rd = '{32'h11110000, 32'h22220000, 32'h33330000};
    route = '{2'b10, 2'b01, 2'b10};
    do_reset();
    mem_gnt = 1;
    instr_req = 1; instr_addr = 32'h10;
    #1;
    tick();
    instr_req = 0; data_req = 1; data_addr = 32'h20;
    #1;
    checks++;
    if (data_gnt !== 1'b1) begin errors++; $display("FAIL ilv_data_gnt got %b exp 1", data_gnt); end
    tick();
    data_req = 0; instr_req = 1; instr_addr = 32'h30;
    #1;
    tick();
    instr_req = 0; mem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1; mem_rdata = rd[i];
      #1;
      checks++;
      if ({instr_rvalid, data_rvalid, instr_rdata, data_rdata} !== {route[i], rd[i], rd[i]}) begin
        errors++;
        $display("FAIL ilv_rsp[%0d] got v=%b%b ird=%h drd=%h exp %b %h", i, instr_rvalid, data_rvalid,
                 instr_rdata, data_rdata, route[i], rd[i]);
      end
      tick();
    end
    mem_rvalid = 0;
  endtask

  task automatic test_error_and_reset;
    mem_rvalid = 1;
    #1;
    checks++;
    if ({instr_rvalid, data_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL err_no_route got %b%b exp 00", instr_rvalid, data_rvalid);
    end
    tick();
    mem_rvalid = 0;
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err_o); end
    tick();
    tick();
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
    instr_req = 1; mem_gnt = 1;
    tick();
    tick();
    instr_req = 0; mem_gnt = 0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL err_busy_before_rst got %b exp 1", busy_o); end
    rst_ni = 0;
    #1;
    checks++;
    if ({busy_o, err_o} !== 2'b00) begin
      errors++;
      $display("FAIL async_rst got busy=%b err=%b exp 0 0", busy_o, err_o);
    end
    rst_ni = 1;
    mem_rvalid = 1;
    #1;
    checks++;
    if ({instr_rvalid, data_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_forgotten got %b%b exp 00", instr_rvalid, data_rvalid);
    end
    tick();
    mem_rvalid = 0;
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL rst_late_err got %b exp 1", err_o); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_gnt_stall();
    test_full();
    test_interleaved();
    test_error_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Merges the two OBI master ports that `gpgpu_top` exposes in the CACHE build (`instr_mem_*` for instruction-cache refills, `data_mem_*` for data-cache refills and writebacks) into a single OBI master toward the host memory bus. Arbitration between the two ports is round-robin with grant locking, and up to `MAX_OUTSTANDING` transactions may be in flight. Responses return in order and are routed back to the requesting port through a source-ID FIFO.

## Interface
- `MAX_OUTSTANDING`, 4: route-FIFO depth and maximum number of granted-but-unanswered transactions; power of two, ≥2.
- `clk_i`  in  1  clock; must be the same clock that drives the `gpgpu_top` memory ports.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `instr_req`  `obi_req_if.slave`  req, gnt, addr[31:0], we, be[3:0], wdata[31:0]  request from `gpgpu_top.instr_mem_req`.
- `instr_rsp`  `obi_rsp_if.master`  rvalid, rdata[31:0]  response to `gpgpu_top.instr_mem_rsp`.
- `data_req`  `obi_req_if.slave`  same fields as `instr_req`  request from `gpgpu_top.data_mem_req`.
- `data_rsp`  `obi_rsp_if.master`  same fields as `instr_rsp`  response to `gpgpu_top.data_mem_rsp`.
- `mem_req`  `obi_req_if.master`  same fields as `instr_req`  merged request to the host bus.
- `mem_rsp`  `obi_rsp_if.slave`  same fields as `instr_rsp`  response from the host bus.
- `busy_o`  out  1  high while the outstanding count is nonzero.
- `err_o`  out  1  sticky; set when `mem_rsp.rvalid` arrives with the route FIFO empty.

## Operation
- Source IDs: 0 = instr, 1 = data.
- Round-robin pointer `rr_q` names the favoured port. Reset value is 0 (instr).
- Selection, in priority order:
  - If `lock_q` is set, select `lock_src_q`.
  - Otherwise, if only one port has `req` high, select that port.
  - Otherwise, if both have `req` high, select `rr_q`.
- `mem_req.req` = selected port's `req` AND NOT `full`. `addr`, `we`, `be` and `wdata` are muxed from the selected port.
- Selected port's `gnt` = `mem_req.gnt` AND `mem_req.req`. The unselected port's `gnt` is 0.
- Handshake is `mem_req.req && mem_req.gnt`. On a handshake:
  - push the source ID into the route FIFO;
  - set `rr_q` to the other port;
  - clear `lock_q`.
- If `mem_req.req` is high and `mem_req.gnt` is low, set `lock_q` and `lock_src_q` = the selected port. This keeps the OBI request stable until it is granted.
- Route FIFO:
  - depth `MAX_OUTSTANDING`, 1-bit entries, counter width $clog2(MAX_OUTSTANDING+1);
  - `full` = count equals `MAX_OUTSTANDING`;
  - pop on `mem_rsp.rvalid` when the FIFO is not empty.
- Response routing:
  - `instr_rsp.rvalid` = `mem_rsp.rvalid` AND not empty AND head = 0.
  - `data_rsp.rvalid` = `mem_rsp.rvalid` AND not empty AND head = 1.
  - `rdata` is broadcast to both ports.
- Boundary behaviour:
  - Full FIFO with a pop in the same cycle: the request stays blocked that cycle (`full` is evaluated from registered state). The push happens the next cycle.
  - Push and pop in the same cycle, not full: count is unchanged and the pointers advance.
  - `rvalid` with an empty FIFO: the response is dropped, no port `rvalid` is asserted, and `err_o` is set. `err_o` clears only on reset.
  - Pointer wrap-around: read and write pointers are log2(MAX_OUTSTANDING) bits and wrap naturally.
  - Reset mid-operation: all state returns to reset values and in-flight transactions are forgotten. Responses arriving after reset set `err_o`. The host must be reset together with this block.

## Timing
- Reset values:
  - `instr_req.gnt`, `data_req.gnt`, `mem_req.req`, `instr_rsp.rvalid`, `data_rsp.rvalid`, `busy_o`, `err_o`: all 0.
  - `rr_q` = 0, `lock_q` = 0, FIFO count and pointers = 0.
- Request path is combinational: 0-cycle latency from port `req` to `mem_req.req`, and from `mem_req.gnt` to port `gnt`.
- Response path is combinational: 0-cycle latency from `mem_rsp.rvalid` to port `rvalid`.
- The host must deliver `rvalid` at least 1 cycle after the corresponding grant. A grant and its response in the same cycle is illegal.
- Sustained throughput is 1 handshake per cycle, alternating between ports when both request continuously.
- `busy_o` is registered and rises the cycle after the first handshake.

## Test plan
- Single instr read: `instr_req.addr`=0x1000, host grants in the same cycle and returns `rdata`=0xDEADBEEF 2 cycles later -> `instr_rsp.rvalid` pulses once with 0xDEADBEEF; `data_rsp.rvalid` stays 0; `busy_o` is 1 for 2 cycles.
- Both ports request continuously, host always grants -> grants alternate instr, data, instr, data…, with instr first after reset.
- Host holds `gnt`=0 for 3 cycles while both ports request -> the selected port's `addr`/`wdata` stay stable and are not swapped; the other port is granted only after that handshake.
- Host never responds, 6 back-to-back requests with `MAX_OUTSTANDING`=4 -> exactly 4 grants, then `mem_req.req`=0. After 1 response, the 5th request is granted the next cycle.
- Interleaved instr/data/instr requests, responses returned in order -> `rvalid` is routed to ports I, D, I respectively with the matching `rdata`.
- `mem_rsp.rvalid` pulsed with nothing outstanding -> no port `rvalid`, `err_o`=1 and held. Asserting `rst_ni`=0 with 2 transactions outstanding -> `busy_o`=0 and `err_o`=0 immediately.
